// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART subsystem.
//   - rx_state_t : receiver frame states
//   - OS_RATE    : oversampling factor (samples per bit)
//   - calc_div   : clocks per oversampling tick, floored and clamped to >= 1
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OS_RATE = 16;

  // Integer floor of clk_freq / (baud * OS_RATE); a zero result would stall
  // the tick generator, so it is clamped up to one clock per tick.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OS_RATE);
    if (d < 1) begin
      d = 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Emits a one-cycle tick every DIV clocks. Clearing restarts the count so
//   the next tick lands exactly DIV clocks after clr.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : restart the divider (no tick is produced in the clearing cycle)
//   tick : one-cycle pulse every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter runs 0..DIV-1; the tick is the terminal count, suppressed
  // while clearing so a restart never leaks a stale tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST) && !clr;

  // Divider count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16
//   16x oversampling UART receiver with 3-sample majority vote per bit,
//   false-start rejection, stop-bit check, optional parity check and a
//   valid/ready output register with overrun reporting.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   rx_in      : serial line, idle high, asynchronous to clk
//   rx_data    : received byte, LSB first on the line
//   rx_valid   : rx_data and error flags are valid
//   rx_ready   : consumer accepts the byte when rx_valid && rx_ready
//   frame_err  : stop bit sampled low (qualified by rx_valid)
//   parity_err : parity mismatch (qualified by rx_valid)
//   overrun    : one-cycle pulse when a completed byte is dropped
//   busy       : receiver is inside a frame
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] fill_q;
  logic       rxs;

  rx_state_t  state_q;
  rx_state_t  state_d;
  logic [3:0] sc_q;
  logic [3:0] sc_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic       s0_q;
  logic       s0_d;
  logic       s1_q;
  logic       s1_d;
  logic       perr_q;
  logic       perr_d;

  logic       tick;
  logic       clr;
  logic       start_edge;
  logic       sample_pt;
  logic       wrap;
  logic       maj;
  logic       deliver;
  logic       load;

  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       frame_err_q;
  logic       parity_err_q;
  logic       overrun_q;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // fill_q marks when prev_q holds a genuinely sampled line value rather than
  // the reset preset, so a line held low across reset release is not
  // mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 3'b000;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  assign rxs        = sync2_q;
  assign start_edge = fill_q[2] && prev_q && !rxs;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // sc = 9 is the third capture of the bit centre; sc = 15 ends the bit.
  assign sample_pt = tick && (sc_q == 4'd9);
  assign wrap      = tick && (sc_q == 4'd15);
  assign maj       = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

  // Frame sequencer: advances the sample counter on every tick inside a
  // frame, captures the first two centre samples, and acts on the majority
  // at the third. The stop bit delivers as soon as its vote is known so the
  // receiver is back in IDLE before the next start edge can arrive.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    perr_d  = perr_q;
    clr     = 1'b0;
    deliver = 1'b0;

    if ((state_q != IDLE) && tick) begin
      sc_d = sc_q + 4'd1;
      if (sc_q == 4'd7) begin
        s0_d = rxs;
      end
      if (sc_q == 4'd8) begin
        s1_d = rxs;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          sc_d    = 4'd0;
          idx_d   = 3'd0;
          perr_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      START: begin
        if (sample_pt && maj) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (sample_pt) begin
          shift_d[idx_q] = maj;
        end
        if (wrap) begin
          if (idx_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sample_pt) begin
          perr_d = maj ^ (^shift_q) ^ PARITY_ODD;
        end
        if (wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_pt) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= 4'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      perr_q  <= perr_d;
    end
  end

  // A new byte may take the output register when it is empty or being
  // drained in this same cycle; otherwise the new byte is the one dropped.
  assign load = deliver && (!rx_valid_q || rx_ready);

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (load) begin
        rx_data_q    <= shift_q;
        frame_err_q  <= !maj;
        parity_err_q <= PARITY_EN && perr_q;
        rx_valid_q   <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q   <= 1'b0;
      end
      overrun_q <= deliver && !load;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
